// File: rtl/agp32_mem_ctrl_pkg.sv
// agp32_mem_pkg: shared command, error and state encodings for the agp32 memory controller
package agp32_mem_pkg;
    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_FETCH     = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_INTERRUPT = 3'd4
    } cmd_t;
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_t;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_ERR} state_t;
    localparam logic [31:0] NOP_INSTR = 32'd63;
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/agp32_mem_ctrl_if.sv
// agp32_mem_ctrl_if: core command/result signals plus the req/ack RAM bus
interface agp32_mem_ctrl_if;
    import agp32_mem_pkg::*;
    logic [2:0]  command;
    logic [31:0] pc;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        init_done;
    logic        ready;
    logic [31:0] inst_rdata;
    logic [31:0] data_rdata;
    logic        mem_start_ready;
    err_t        error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport slave (
        input  command, pc, data_addr, data_wdata, data_wstrb, init_done, mem_ack, mem_rdata,
        output ready, inst_rdata, data_rdata, mem_start_ready, error,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
    modport master (
        output command, pc, data_addr, data_wdata, data_wstrb, init_done, mem_ack, mem_rdata,
        input  ready, inst_rdata, data_rdata, mem_start_ready, error,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/agp32_mem_ctrl_watchdog.sv
// agp32_mem_watchdog: counts unacknowledged bus cycles, flags the cycle that reaches the terminal count
module agp32_mem_watchdog #(
    parameter int TC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    logic [15:0] r_cnt;
    // count enabled cycles since the last clear
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 16'd1;
    end
    // expires on the cycle whose increment would reach TC
    always_comb o_expired = i_en && (r_cnt == 16'(TC - 1));
endmodule

// File: rtl/agp32_mem_ctrl.sv
// agp32_mem_ctrl: turns core command pulses into single-outstanding req/ack RAM accesses
module agp32_mem_ctrl
    import agp32_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst_n,
    agp32_mem_ctrl_if.slave bus
);
    state_t      r_state;
    err_t        r_err;
    logic        r_ready;
    logic        r_start;
    logic        r_req;
    logic        r_we;
    logic        r_fetch;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_inst;
    logic [31:0] r_data;
    logic        w_expired;
    logic        w_wd_en;
    logic        w_wd_clr;
    // watchdog runs only while waiting for an ack in BUSY
    always_comb begin
        w_wd_clr = r_state != ST_BUSY;
        w_wd_en  = (r_state == ST_BUSY) && !bus.mem_ack;
    end
    agp32_mem_watchdog #(.TC(TIMEOUT_CYCLES)) u_wd (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );
    // controller FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_err   <= ERR_NONE;
            r_ready <= 1'b0;
            r_start <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_fetch <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_inst  <= NOP_INSTR;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_INIT: if (bus.init_done) begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b1;
                    r_ready <= 1'b1;
                end
                ST_IDLE: case (bus.command)
                    CMD_FETCH: if (bus.pc[1:0] != 2'b00) begin
                        r_err   <= ERR_MISALIGN;
                        r_state <= ST_ERR;
                        r_ready <= 1'b0;
                    end else begin
                        r_addr  <= word_addr(bus.pc);
                        r_we    <= 1'b0;
                        r_wstrb <= '0;
                        r_fetch <= 1'b1;
                        r_req   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= ST_BUSY;
                    end
                    CMD_READ: begin
                        r_addr  <= word_addr(bus.data_addr);
                        r_we    <= 1'b0;
                        r_wstrb <= '0;
                        r_fetch <= 1'b0;
                        r_req   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= ST_BUSY;
                    end
                    CMD_WRITE: if (bus.data_wstrb == 4'hF && bus.data_addr[1:0] != 2'b00) begin
                        r_err   <= ERR_MISALIGN;
                        r_state <= ST_ERR;
                        r_ready <= 1'b0;
                    end else begin
                        r_addr  <= word_addr(bus.data_addr);
                        r_we    <= 1'b1;
                        r_wdata <= bus.data_wdata;
                        r_wstrb <= bus.data_wstrb;
                        r_fetch <= 1'b0;
                        r_req   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= ST_BUSY;
                    end
                    CMD_INTERRUPT: r_ready <= 1'b0;
                    default: r_ready <= 1'b1;
                endcase
                ST_BUSY: if (bus.mem_ack) begin
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                    if (!r_we && r_fetch) r_inst <= bus.mem_rdata;
                    if (!r_we && !r_fetch) r_data <= bus.mem_rdata;
                end else if (w_expired) begin
                    r_req   <= 1'b0;
                    r_err   <= ERR_TIMEOUT;
                    r_state <= ST_ERR;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
    // drive the interface from the registered state
    always_comb begin
        bus.ready           = r_ready;
        bus.inst_rdata      = r_inst;
        bus.data_rdata      = r_data;
        bus.mem_start_ready = r_start;
        bus.error           = r_err;
        bus.mem_req         = r_req;
        bus.mem_we          = r_we;
        bus.mem_addr        = r_addr;
        bus.mem_wdata       = r_wdata;
        bus.mem_wstrb       = r_wstrb;
    end
endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// tb_agp32_mem_ctrl: scoreboard bench for the agp32 memory controller
module tb_agp32_mem_ctrl;
    import agp32_mem_pkg::*;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;
    typedef struct {
        logic [31:0] inst;
        logic [31:0] data;
        logic [1:0]  err;
        int          low;
    } resp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int ack_delay = -1;
    logic [31:0] ack_data = '0;
    int late_req = 0;
    int late_done = 0;
    bus_t bus_q[$];
    resp_t resp_q[$];
    agp32_mem_ctrl_if bus();
    agp32_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask
    // RAM model: acks the ack_delay-th cycle of a request, or on demand for late-ack tests
    initial begin
        int rcnt;
        logic acked;
        rcnt = 0;
        acked = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (late_req != late_done) begin
                late_done = late_req;
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 32'hFEEDFACE;
            end else if (bus.mem_req && !acked) begin
                rcnt++;
                if (rcnt == ack_delay) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = ack_data;
                    acked = 1'b1;
                end
            end else if (!bus.mem_req) begin
                rcnt = 0;
                acked = 1'b0;
            end
        end
    end
    // monitor: checks each new bus request and each return of ready against the queues
    initial begin
        logic prev_req, prev_rdy;
        int low;
        bus_t b;
        resp_t r;
        prev_req = 1'b0;
        prev_rdy = 1'b0;
        low = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                prev_rdy = 1'b0;
                low = 0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req actual=%h expected=none", bus.mem_addr);
                    end else begin
                        b = bus_q.pop_front();
                        chk("mem_addr", bus.mem_addr, b.addr);
                        chk("mem_we", 32'(bus.mem_we), 32'(b.we));
                        if (b.we) begin
                            chk("mem_wdata", bus.mem_wdata, b.wdata);
                            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(b.wstrb));
                        end
                    end
                end
                if (bus.ready && !prev_rdy) begin
                    if (resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready actual=1 expected=0");
                    end else begin
                        r = resp_q.pop_front();
                        chk("inst_rdata", bus.inst_rdata, r.inst);
                        chk("data_rdata", bus.data_rdata, r.data);
                        chk("error", 32'(bus.error), 32'(r.err));
                        if (r.low >= 0) chk("ready_low_cycles", 32'(low), 32'(r.low));
                    end
                end
                low = bus.ready ? 0 : low + 1;
                prev_req = bus.mem_req;
                prev_rdy = bus.ready;
            end
        end
    end
    task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
        bus_t b;
        b.addr = a;
        b.we = we;
        b.wdata = wd;
        b.wstrb = ws;
        bus_q.push_back(b);
    endtask
    task automatic push_resp(input logic [31:0] inst, input logic [31:0] data, input logic [1:0] err, input int low);
        resp_t r;
        r.inst = inst;
        r.data = data;
        r.err = err;
        r.low = low;
        resp_q.push_back(r);
    endtask
    task automatic issue(input logic [2:0] c, input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        @(negedge clk);
        bus.command = c;
        bus.pc = p;
        bus.data_addr = a;
        bus.data_wdata = wd;
        bus.data_wstrb = ws;
        @(negedge clk);
        bus.command = CMD_NONE;
    endtask
    task automatic wait_ready(input string n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (bus.ready) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=ready0 expected=ready1", n);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.init_done = 1'b0;
        bus.command = CMD_NONE;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_start", 32'(bus.mem_start_ready), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_inst", bus.inst_rdata, 32'd63);
        chk("rst_data", bus.data_rdata, 32'd0);
        rst_n = 1'b1;
    endtask
    task automatic do_init();
        push_resp(32'd63, 32'd0, 2'd0, -1);
        repeat (5) @(negedge clk);
        chk("init_start_pre", 32'(bus.mem_start_ready), 32'd0);
        bus.init_done = 1'b1;
        @(negedge clk);
        chk("init_start", 32'(bus.mem_start_ready), 32'd1);
        chk("init_ready", 32'(bus.ready), 32'd1);
    endtask
    initial begin
        int n;
        bus.command = CMD_NONE;
        bus.pc = '0;
        bus.data_addr = '0;
        bus.data_wdata = '0;
        bus.data_wstrb = '0;
        bus.init_done = 1'b0;
        do_reset();
        do_init();
        ack_delay = 3;
        ack_data = 32'hDEADBEEF;
        push_bus(32'h100, 1'b0, '0, '0);
        push_resp(32'hDEADBEEF, 32'd0, 2'd0, 3);
        issue(CMD_FETCH, 32'h100, '0, '0, '0);
        wait_ready("fetch", 20);
        ack_delay = 1;
        ack_data = 32'h11223344;
        push_bus(32'h200, 1'b0, '0, '0);
        push_resp(32'hDEADBEEF, 32'h11223344, 2'd0, 1);
        issue(CMD_READ, '0, 32'h203, '0, '0);
        wait_ready("read", 20);
        ack_delay = 2;
        ack_data = 32'hBAD0BAD0;
        push_bus(32'h300, 1'b1, 32'h00AB0000, 4'b0100);
        push_resp(32'hDEADBEEF, 32'h11223344, 2'd0, 2);
        issue(CMD_WRITE, '0, 32'h302, 32'h00AB0000, 4'b0100);
        wait_ready("bytewrite", 20);
        push_resp(32'hDEADBEEF, 32'h11223344, 2'd0, 1);
        issue(CMD_INTERRUPT, '0, '0, '0, '0);
        wait_ready("interrupt", 20);
        ack_delay = 4;
        ack_data = 32'h55667788;
        push_bus(32'h400, 1'b0, '0, '0);
        push_resp(32'hDEADBEEF, 32'h55667788, 2'd0, 4);
        issue(CMD_READ, '0, 32'h401, '0, '0);
        wait_ready("ack_at_limit", 20);
        chk("ack_at_limit_error", 32'(bus.error), 32'd0);
        ack_delay = -1;
        push_bus(32'h500, 1'b0, '0, '0);
        issue(CMD_READ, '0, 32'h500, '0, '0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req) n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", 32'(n), 32'd4);
        chk("timeout_error", 32'(bus.error), 32'd2);
        chk("timeout_ready", 32'(bus.ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("timeout_sticky", 32'(bus.error), 32'd2);
        do_reset();
        do_init();
        issue(CMD_WRITE, '0, 32'h302, 32'h12345678, 4'hF);
        repeat (3) @(negedge clk);
        chk("wordwrite_error", 32'(bus.error), 32'd1);
        chk("wordwrite_ready", 32'(bus.ready), 32'd0);
        chk("wordwrite_req", 32'(bus.mem_req), 32'd0);
        do_reset();
        do_init();
        issue(CMD_FETCH, 32'h102, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("fetchmis_error", 32'(bus.error), 32'd1);
        chk("fetchmis_req", 32'(bus.mem_req), 32'd0);
        do_reset();
        do_init();
        ack_delay = -1;
        push_bus(32'h600, 1'b0, '0, '0);
        issue(CMD_READ, '0, 32'h600, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.init_done = 1'b0;
        @(negedge clk);
        chk("midrst_req", 32'(bus.mem_req), 32'd0);
        late_req++;
        @(negedge clk);
        rst_n = 1'b1;
        late_req++;
        repeat (3) @(negedge clk);
        chk("late_ready", 32'(bus.ready), 32'd0);
        chk("late_start", 32'(bus.mem_start_ready), 32'd0);
        chk("late_data", bus.data_rdata, 32'd0);
        chk("late_inst", bus.inst_rdata, 32'd63);
        chk("late_req", 32'(bus.mem_req), 32'd0);
        chk("late_error", 32'(bus.error), 32'd0);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
